// File: rtl/mac_accumulator.sv
// ============================================================================
// Module   : mac_accumulator
// Purpose  : Streaming multiply-accumulate stage wrapped around an external
//            16x16 signed combinational multiplier. Operand beats are
//            registered onto mul_a/mul_b. The returned 32-bit product is
//            sign-extended and summed into an ACC_W-bit accumulator. Each
//            frame result is held on a valid/ready output until it is taken.
// Ports    : clk, rst (async active-high)
//            in_valid/in_ready/in_a/in_b/in_last  - operand beat stream
//            mul_a/mul_b -> multiplier, mul_p <- multiplier product
//            out_valid/out_ready/out_acc/out_count/out_ovf - frame result
// Options  : MAC_ACCUMULATOR_SAT_EN - when defined, the accumulator clamps
//            on signed overflow. Otherwise it wraps. out_ovf is set in
//            both cases.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_accumulator #(
  parameter int ACC_W = 40,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [15:0]      in_a,
  input  logic signed [15:0]      in_b,
  input  logic                    in_last,
  output logic signed [15:0]      mul_a,
  output logic signed [15:0]      mul_b,
  input  logic signed [31:0]      mul_p,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_acc,
  output logic        [CNT_W-1:0] out_count,
  output logic                    out_ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic        [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t                  state;
  logic                    s1_valid;
  logic                    s1_last;
  logic signed [ACC_W-1:0] acc;
  logic        [CNT_W-1:0] count;
  logic                    ovf;

  logic                    accept;
  logic                    out_fire;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] acc_next;
  logic                    add_ovf;

  // Input is blocked while a result is pending and while the last beat of
  // the current frame is still in stage 1. This keeps frames from mixing.
  assign in_ready = !rst && (state != HOLD) && !(s1_valid && s1_last);
  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Sign-extend the product. When ACC_W is 32 no padding is needed, and a
  // zero-width replication would be illegal.
  generate
    if (ACC_W > 32) begin : g_ext_pad
      assign prod_ext = {{(ACC_W-32){mul_p[31]}}, mul_p};
    end else begin : g_ext_none
      assign prod_ext = mul_p;
    end
  endgenerate

  assign sum = acc + prod_ext;
  // Signed overflow: both addends have the same sign and the sum sign differs.
  assign add_ovf = (acc[ACC_W-1] == prod_ext[ACC_W-1]) &&
                   (sum[ACC_W-1] != acc[ACC_W-1]);

`ifdef MAC_ACCUMULATOR_SAT_EN
  // Clamp toward the common sign of the addends.
  assign acc_next = add_ovf ? (acc[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum;
`else
  assign acc_next = sum;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mul_a    <= '0;
      mul_b    <= '0;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      acc      <= '0;
      count    <= '0;
      ovf      <= 1'b0;
    end else begin
      // Stage 1: capture operands. The operands hold when no beat is accepted.
      if (accept) begin
        mul_a <= in_a;
        mul_b <= in_b;
      end
      s1_valid <= accept;
      s1_last  <= accept && in_last;

      case (state)
        IDLE:    if (accept) state <= RUN;
        RUN:     if (s1_valid && s1_last) state <= HOLD;
        HOLD:    if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase

      // Stage 2: absorb the product. No product can be in flight during HOLD,
      // so the clear on handshake never competes with an accumulate.
      if (out_fire) begin
        acc   <= '0;
        count <= '0;
        ovf   <= 1'b0;
      end else if (s1_valid) begin
        acc <= acc_next;
        if (count != CNT_MAX) count <= count + 1'b1;
        ovf <= ovf | add_ovf;
      end
    end
  end

  assign out_valid = (state == HOLD);
  assign out_acc   = acc;
  assign out_count = count;
  assign out_ovf   = ovf;

endmodule

`default_nettype wire

// File: tb/tb_mac_accumulator.sv
// ============================================================================
// Module   : tb_mac_accumulator
// Purpose  : Self-checking bench for mac_accumulator. Two instances, with
//            ACC_W=40 and ACC_W=32, receive the same operand stream. Expected
//            frame results are queued per instance and popped by a monitor
//            on each output handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mac_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               in_valid;
  logic signed [15:0] in_a;
  logic signed [15:0] in_b;
  logic               in_last;
  logic               out_ready;

  // ACC_W = 40 instance
  logic               in_ready40, out_valid40, out_ovf40;
  logic signed [15:0] mul_a40, mul_b40;
  logic signed [31:0] mul_p40;
  logic [39:0]        out_acc40;
  logic [7:0]         out_count40;

  // ACC_W = 32 instance
  logic               in_ready32, out_valid32, out_ovf32;
  logic signed [15:0] mul_a32, mul_b32;
  logic signed [31:0] mul_p32;
  logic [31:0]        out_acc32;
  logic [7:0]         out_count32;

  // Behavioural stand-ins for Multiplier_top
  assign mul_p40 = mul_a40 * mul_b40;
  assign mul_p32 = mul_a32 * mul_b32;

  mac_accumulator #(.ACC_W(40), .CNT_W(8)) dut40 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready40),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .mul_a(mul_a40), .mul_b(mul_b40), .mul_p(mul_p40),
    .out_valid(out_valid40), .out_ready(out_ready), .out_acc(out_acc40),
    .out_count(out_count40), .out_ovf(out_ovf40)
  );

  mac_accumulator #(.ACC_W(32), .CNT_W(8)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .mul_a(mul_a32), .mul_b(mul_b32), .mul_p(mul_p32),
    .out_valid(out_valid32), .out_ready(out_ready), .out_acc(out_acc32),
    .out_count(out_count32), .out_ovf(out_ovf32)
  );

  typedef struct { logic [39:0] acc; logic [7:0] cnt; logic ovf; } exp40_t;
  typedef struct { logic [31:0] acc; logic [7:0] cnt; logic ovf; } exp32_t;

  exp40_t q40[$];
  exp32_t q32[$];
  exp40_t it40;
  exp32_t it32;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic push(input longint a40, input longint a32, input int cnt,
                      input bit o40, input bit o32);
    exp40_t e40;
    exp32_t e32;
    e40.acc = a40[39:0]; e40.cnt = cnt[7:0]; e40.ovf = o40;
    e32.acc = a32[31:0]; e32.cnt = cnt[7:0]; e32.ovf = o32;
    q40.push_back(e40);
    q32.push_back(e32);
  endtask

  // Present one beat, wait for it to be accepted, then drop in_valid.
  task automatic drive(input int a, input int b, input bit last);
    int n = 0;
    while (!(in_ready40 && in_ready32) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n == 50) chk("in_ready_timeout", 64'(0), 64'(1));
    in_valid = 1'b1; in_a = a[15:0]; in_b = b[15:0]; in_last = last;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Wait for the result to appear, then let the handshake edge pass.
  task automatic wait_result();
    int n = 0;
    while (!out_valid40 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n == 50) chk("out_valid_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor: compare on each output handshake.
  always @(negedge clk) begin
    if (!rst && out_ready) begin
      if (out_valid40) begin
        if (q40.size() == 0) chk("unexpected_out40", 64'(1), 64'(0));
        else begin
          it40 = q40.pop_front();
          chk("acc40", 64'(out_acc40), 64'(it40.acc));
          chk("count40", 64'(out_count40), 64'(it40.cnt));
          chk("ovf40", 64'(out_ovf40), 64'(it40.ovf));
        end
      end
      if (out_valid32) begin
        if (q32.size() == 0) chk("unexpected_out32", 64'(1), 64'(0));
        else begin
          it32 = q32.pop_front();
          chk("acc32", 64'(out_acc32), 64'(it32.acc));
          chk("count32", 64'(out_count32), 64'(it32.cnt));
          chk("ovf32", 64'(out_ovf32), 64'(it32.ovf));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("rst_in_ready", 64'(in_ready40), 64'(0));
    chk("rst_out_valid", 64'(out_valid40), 64'(0));
    chk("rst_out_acc", 64'(out_acc40), 64'(0));
    rst = 1'b0; #1;
    chk("rel_in_ready", 64'(in_ready40), 64'(1));

    // 1: single-beat frame, with a latency check
    push(-209676664, -209676664, 1, 0, 0);
    drive(25244, -8306, 1);
    chk("t1_lat_n1", 64'(out_valid40), 64'(0));
    @(posedge clk); #1;
    chk("t1_lat_n2", 64'(out_valid40), 64'(1));
    @(posedge clk); #1;
    chk("t1_cleared", 64'(out_valid40), 64'(0));

    // 2: three back-to-back beats, with the result held back
    out_ready = 1'b0;
    push(11, 11, 3, 0, 0);
    drive(-5, 2, 0);
    chk("t2_ready_b1", 64'(in_ready40), 64'(1));
    drive(-7, -3, 0);
    chk("t2_ready_b2", 64'(in_ready40), 64'(1));
    drive(0, 7, 1);
    chk("t2_ready_last", 64'(in_ready40), 64'(0));

    // 3: backpressure stability, then a new frame
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", 64'(out_valid40), 64'(1));
      chk("t3_hold_acc", 64'(out_acc40), 64'(11));
      chk("t3_hold_count", 64'(out_count40), 64'(3));
      chk("t3_hold_in_ready", 64'(in_ready40), 64'(0));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t3_released", 64'(out_valid40), 64'(0));
    push(-32767, -32767, 1, 0, 0);
    drive(32767, -1, 1);
    wait_result();

    // 4: overflow at ACC_W=32, no overflow at ACC_W=40
`ifdef MAC_ACCUMULATOR_SAT_EN
    push(64'd3221028867, 2147483647, 3, 0, 1);
`else
    push(64'd3221028867, -1073938429, 3, 0, 1);
`endif
    drive(32767, 32767, 0);
    drive(32767, 32767, 0);
    drive(32767, 32767, 1);
    wait_result();
    push(1, 1, 1, 0, 0);
    drive(1, 1, 1);
    wait_result();

    // 5: corner product
    push(1073741824, 1073741824, 1, 0, 0);
    drive(-32768, -32768, 1);
    wait_result();

    // 6: reset mid-frame discards the frame
    drive(5, 5, 0);
    drive(6, 6, 0);
    #3 rst = 1'b1;
    #1;
    chk("t6_acc40", 64'(out_acc40), 64'(0));
    chk("t6_acc32", 64'(out_acc32), 64'(0));
    chk("t6_count", 64'(out_count40), 64'(0));
    chk("t6_valid", 64'(out_valid40), 64'(0));
    chk("t6_in_ready", 64'(in_ready40), 64'(0));
    chk("t6_mul_a", 64'(mul_a40), 64'(0));
    chk("t6_mul_b", 64'(mul_b32), 64'(0));
    chk("t6_ovf", 64'(out_ovf40), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0; #1;
    chk("t6_rel_in_ready", 64'(in_ready40), 64'(1));
    push(12, 12, 1, 0, 0);
    drive(3, 4, 1);
    wait_result();

    repeat (3) @(posedge clk); #1;
    chk("queues_drained", 64'(q40.size() + q32.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
